// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory bus arbiter: bus widths, zero
// constants, polarity constants and FSM state encodings.
package mem_bus_arbiter_pkg;

  localparam int unsigned DataBus = 32;
  localparam int unsigned AddrBus = 32;
  localparam int unsigned SelBus  = 4;

  localparam logic [DataBus-1:0] ZeroData     = '0;
  localparam logic [AddrBus-1:0] ZeroDataAddr = '0;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [SelBus-1:0] SelAll = '1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_IF   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/ack bundle between the IF stage, the MEM stage, pipeline control
// and the external memory bus. The arbiter uses the master modport; the
// surrounding pipeline and memory slave use the slave modport.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrBus,
  parameter int unsigned DATA_W = DataBus
);

  logic                if_req_i;
  logic [ADDR_W-1:0]   if_addr_i;
  logic [DATA_W-1:0]   if_rdata_o;
  logic                if_ack_o;

  logic                mem_req_i;
  logic                mem_we_i;
  logic [ADDR_W-1:0]   mem_addr_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic [SelBus-1:0]   mem_sel_i;
  logic [DATA_W-1:0]   mem_rdata_o;
  logic                mem_ack_o;

  logic                bus_req_o;
  logic                bus_we_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W-1:0]   bus_wdata_o;
  logic [SelBus-1:0]   bus_sel_o;
  logic [DATA_W-1:0]   bus_rdata_i;
  logic                bus_ack_i;

  logic                err_o;
  logic                stall_req_o;

  modport master (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    input  bus_rdata_i, bus_ack_i,
    output if_rdata_o, if_ack_o,
    output mem_rdata_o, mem_ack_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    output err_o, stall_req_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    output bus_rdata_i, bus_ack_i,
    input  if_rdata_o, if_ack_o,
    input  mem_rdata_o, mem_ack_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    input  err_o, stall_req_o
  );

endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus cycle watchdog: counts BUSY cycles without a slave ack and flags a
// timeout once the count reaches TIMEOUT_CYCLES. Only built with
// BUS_TIMEOUT_EN.
module mem_bus_arbiter_bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic busy,
  input  logic bus_ack,
  output logic timeout_c
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Cycle counter: cleared on grant, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else if (grant) begin
      cnt_q <= '0;
    end else if (busy && !bus_ack && (cnt_q != CntW'(TIMEOUT_CYCLES))) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout_c = busy && (cnt_q == CntW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-ported external memory bus between instruction fetch
// and load/store. MEM has fixed priority over IF. Optional bus watchdog is
// enabled with the BUS_TIMEOUT_EN macro.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = AddrBus,
  parameter int unsigned DATA_W         = DataBus,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);

  arb_state_t state_q, state_d;

  logic              bus_req_q,   bus_req_d;
  logic              bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [SelBus-1:0] bus_sel_q,   bus_sel_d;
  logic              if_ack_q,    if_ack_d;
  logic              mem_ack_q,   mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              err_q,       err_d;

  logic grant_c;
  logic busy_c;
  logic timeout_c;

  assign busy_c = (state_q != ARB_IDLE);

`ifdef BUS_TIMEOUT_EN
  mem_bus_arbiter_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant_c),
    .busy      (busy_c),
    .bus_ack   (bus.bus_ack_i),
    .timeout_c (timeout_c)
  );
`else
  // Without the watchdog a BUSY state waits for the slave indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_c = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= WriteDisable;
      bus_addr_q  <= ADDR_W'(ZeroDataAddr);
      bus_wdata_q <= DATA_W'(ZeroData);
      bus_sel_q   <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= DATA_W'(ZeroData);
      mem_rdata_q <= DATA_W'(ZeroData);
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  // Next state: grant in IDLE (a requester with ack high is ineligible),
  // complete in BUSY on slave ack or watchdog timeout.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    err_d       = 1'b0;
    grant_c     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (bus.mem_req_i && !mem_ack_q) begin
          state_d     = ARB_MEM;
          grant_c     = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = bus.mem_we_i;
          bus_addr_d  = bus.mem_addr_i;
          bus_wdata_d = bus.mem_wdata_i;
          bus_sel_d   = bus.mem_sel_i;
        end else if (bus.if_req_i && !if_ack_q) begin
          state_d     = ARB_IF;
          grant_c     = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = WriteDisable;
          bus_addr_d  = bus.if_addr_i;
          bus_wdata_d = DATA_W'(ZeroData);
          bus_sel_d   = SelAll;
        end
      end
      ARB_MEM, ARB_IF: begin
        if (bus.bus_ack_i || timeout_c) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
          err_d     = !bus.bus_ack_i;
          if (state_q == ARB_MEM) begin
            mem_ack_d = 1'b1;
            if (!bus.bus_ack_i) begin
              mem_rdata_d = DATA_W'(ZeroData);
            end else if (bus_we_q != WriteEnable) begin
              mem_rdata_d = bus.bus_rdata_i;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.bus_ack_i ? bus.bus_rdata_i : DATA_W'(ZeroData);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_wdata_o = bus_wdata_q;
  assign bus.bus_sel_o   = bus_sel_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.mem_ack_o   = mem_ack_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.err_o       = err_q;

  // Stall while any requester is still waiting for its ack.
  assign bus.stall_req_o = (bus.if_req_i & ~if_ack_q) | (bus.mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. With BUS_TIMEOUT_EN defined the DUT is
// built with a 4-cycle watchdog and the timeout sequence is exercised too.
module tb_mem_bus_arbiter;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned Tmo = 4;
`else
  localparam int unsigned Tmo = 255;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_bus_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst             = 1'b1;
    bif.if_req_i    = 1'b0;
    bif.if_addr_i   = '0;
    bif.mem_req_i   = 1'b0;
    bif.mem_we_i    = 1'b0;
    bif.mem_addr_i  = '0;
    bif.mem_wdata_i = '0;
    bif.mem_sel_i   = '0;
    bif.bus_rdata_i = '0;
    bif.bus_ack_i   = 1'b0;

    // Reset state
    tick();
    tick();
    chk1("rst_bus_req", bif.bus_req_o, 1'b0);
    chk1("rst_mem_ack", bif.mem_ack_o, 1'b0);
    chk1("rst_if_ack", bif.if_ack_o, 1'b0);
    chk1("rst_err", bif.err_o, 1'b0);
    chk32("rst_mem_rdata", bif.mem_rdata_o, 32'h0);
    chk1("rst_stall", bif.stall_req_o, 1'b0);
    rst = 1'b0;
    tick();

    // MEM load, slave acks 2 cycles after bus_req_o
    bif.mem_req_i  = 1'b1;
    bif.mem_we_i   = 1'b0;
    bif.mem_addr_i = 32'h100;
    bif.mem_sel_i  = 4'hf;
    #1;
    chk1("ld_stall_req", bif.stall_req_o, 1'b1);
    tick();
    chk1("ld_bus_req1", bif.bus_req_o, 1'b1);
    chk32("ld_bus_addr1", bif.bus_addr_o, 32'h100);
    chk1("ld_bus_we", bif.bus_we_o, 1'b0);
    chk1("ld_stall1", bif.stall_req_o, 1'b1);
    tick();
    chk1("ld_bus_req2", bif.bus_req_o, 1'b1);
    chk1("ld_no_ack_yet", bif.mem_ack_o, 1'b0);
    tick();
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'hDEADBEEF;
    #1;
    chk1("ld_stall_ackcyc_before", bif.stall_req_o, 1'b1);
    tick();
    chk1("ld_mem_ack", bif.mem_ack_o, 1'b1);
    chk32("ld_mem_rdata", bif.mem_rdata_o, 32'hDEADBEEF);
    chk1("ld_bus_req_drop", bif.bus_req_o, 1'b0);
    chk1("ld_stall_in_ack", bif.stall_req_o, 1'b0);
    chk1("ld_err", bif.err_o, 1'b0);
    // Request still held during the ack cycle: must not reissue.
    bif.bus_ack_i = 1'b0;
    tick();
    chk1("ld_single_issue", bif.bus_req_o, 1'b0);
    chk1("ld_ack_one_cycle", bif.mem_ack_o, 1'b0);
    bif.mem_req_i = 1'b0;
    tick();
    chk1("ld_idle", bif.bus_req_o, 1'b0);
    chk32("ld_rdata_hold", bif.mem_rdata_o, 32'hDEADBEEF);

    // IF and MEM together, zero-wait slave (ack held high, ignored in IDLE)
    bif.mem_req_i   = 1'b1;
    bif.mem_we_i    = 1'b0;
    bif.mem_addr_i  = 32'h200;
    bif.mem_sel_i   = 4'hf;
    bif.if_req_i    = 1'b1;
    bif.if_addr_i   = 32'h40;
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'h11111111;
    tick();
    chk1("pri_bus_req_mem", bif.bus_req_o, 1'b1);
    chk32("pri_addr_mem", bif.bus_addr_o, 32'h200);
    chk1("pri_no_ack", bif.mem_ack_o | bif.if_ack_o, 1'b0);
    tick();
    chk1("pri_mem_ack", bif.mem_ack_o, 1'b1);
    chk32("pri_mem_rdata", bif.mem_rdata_o, 32'h11111111);
    chk1("pri_if_wait", bif.if_ack_o, 1'b0);
    chk1("pri_bus_idle_gap", bif.bus_req_o, 1'b0);
    bif.mem_req_i   = 1'b0;
    bif.bus_rdata_i = 32'h22222222;
    tick();
    chk1("pri_bus_req_if", bif.bus_req_o, 1'b1);
    chk32("pri_addr_if", bif.bus_addr_o, 32'h40);
    chk32("pri_sel_if", 32'(bif.bus_sel_o), 32'hf);
    chk1("pri_we_if", bif.bus_we_o, 1'b0);
    chk1("pri_stall_if", bif.stall_req_o, 1'b1);
    tick();
    chk1("pri_if_ack", bif.if_ack_o, 1'b1);
    chk32("pri_if_rdata", bif.if_rdata_o, 32'h22222222);
    chk1("pri_mem_ack_off", bif.mem_ack_o, 1'b0);
    chk32("pri_mem_rdata_hold", bif.mem_rdata_o, 32'h11111111);
    bif.if_req_i  = 1'b0;
    bif.bus_ack_i = 1'b0;
    tick();
    chk1("pri_if_ack_pulse", bif.if_ack_o, 1'b0);
    chk1("pri_end_idle", bif.bus_req_o, 1'b0);

    // MEM store; input changes during BUSY must not reach the bus
    bif.mem_req_i   = 1'b1;
    bif.mem_we_i    = 1'b1;
    bif.mem_addr_i  = 32'h300;
    bif.mem_wdata_i = 32'h12345678;
    bif.mem_sel_i   = 4'b0011;
    tick();
    chk1("st_bus_req", bif.bus_req_o, 1'b1);
    chk1("st_bus_we", bif.bus_we_o, 1'b1);
    chk32("st_bus_sel", 32'(bif.bus_sel_o), 32'h3);
    chk32("st_bus_wdata", bif.bus_wdata_o, 32'h12345678);
    bif.mem_addr_i  = 32'h999;
    bif.mem_wdata_i = 32'hFFFFFFFF;
    tick();
    chk32("st_addr_stable", bif.bus_addr_o, 32'h300);
    chk32("st_wdata_stable", bif.bus_wdata_o, 32'h12345678);
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'hBADBAD00;
    tick();
    chk1("st_mem_ack", bif.mem_ack_o, 1'b1);
    chk32("st_rdata_unchanged", bif.mem_rdata_o, 32'h11111111);
    chk1("st_no_if_ack", bif.if_ack_o, 1'b0);
    chk32("st_if_rdata_hold", bif.if_rdata_o, 32'h22222222);
    bif.mem_req_i = 1'b0;
    bif.mem_we_i  = 1'b0;
    bif.bus_ack_i = 1'b0;
    tick();

    // Reset during an IF bus cycle, slave acks late
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h80;
    tick();
    chk1("rc_bus_req", bif.bus_req_o, 1'b1);
    rst = 1'b1;
    tick();
    chk1("rc_bus_req_rst", bif.bus_req_o, 1'b0);
    chk32("rc_bus_addr_rst", bif.bus_addr_o, 32'h0);
    chk32("rc_if_rdata_rst", bif.if_rdata_o, 32'h0);
    chk32("rc_mem_rdata_rst", bif.mem_rdata_o, 32'h0);
    rst             = 1'b0;
    bif.if_req_i    = 1'b0;
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'h55555555;
    tick();
    chk1("rc_late_ack_ignored", bif.if_ack_o, 1'b0);
    chk1("rc_idle", bif.bus_req_o, 1'b0);
    chk32("rc_if_rdata", bif.if_rdata_o, 32'h0);
    bif.bus_ack_i = 1'b0;
    tick();

`ifdef BUS_TIMEOUT_EN
    // Watchdog: slave never acks, 4-cycle limit
    bif.mem_req_i  = 1'b1;
    bif.mem_we_i   = 1'b0;
    bif.mem_addr_i = 32'h400;
    bif.mem_sel_i  = 4'hf;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("to_busy", bif.bus_req_o, 1'b1);
      chk1("to_no_ack", bif.mem_ack_o, 1'b0);
    end
    tick();
    chk1("to_mem_ack", bif.mem_ack_o, 1'b1);
    chk1("to_err", bif.err_o, 1'b1);
    chk32("to_rdata_zero", bif.mem_rdata_o, 32'h0);
    chk1("to_bus_drop", bif.bus_req_o, 1'b0);
    bif.mem_req_i = 1'b0;
    tick();
    chk1("to_err_pulse", bif.err_o, 1'b0);
    bif.mem_req_i   = 1'b1;
    bif.bus_ack_i   = 1'b1;
    bif.bus_rdata_i = 32'h77777777;
    tick();
    chk1("to_next_req", bif.bus_req_o, 1'b1);
    tick();
    chk1("to_next_ack", bif.mem_ack_o, 1'b1);
    chk1("to_next_no_err", bif.err_o, 1'b0);
    chk32("to_next_rdata", bif.mem_rdata_o, 32'h77777777);
    bif.mem_req_i = 1'b0;
    bif.bus_ack_i = 1'b0;
    tick();
`else
    chk1("no_timeout_err", bif.err_o, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported external memory bus between instruction fetch (IF) and the load/store stage (MEM) of the 5-stage pipeline.
- Drives a registered request/acknowledge bus transaction for the granted requester and returns read data and acknowledge to it.
- Raises a stall request to pipeline control while any requester is waiting.
- MEM has fixed priority over IF because it belongs to the older instruction.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with BUS_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req_i  in  1  IF read request; held until if_ack_o
- if_addr_i  in  ADDR_W  IF read address
- if_rdata_o  out  DATA_W  IF read data; valid with if_ack_o
- if_ack_o  out  1  one-cycle IF completion pulse
- mem_req_i  in  1  MEM request; held until mem_ack_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  ADDR_W  MEM address
- mem_wdata_i  in  DATA_W  store data
- mem_sel_i  in  4  byte lane enables
- mem_rdata_o  out  DATA_W  load data; valid with mem_ack_o
- mem_ack_o  out  1  one-cycle MEM completion pulse
- bus_req_o  out  1  bus cycle active
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_sel_o  out  4  bus byte enables
- bus_rdata_i  in  DATA_W  bus read data
- bus_ack_i  in  1  slave completion; may be high in the first cycle of bus_req_o
- err_o  out  1  timeout flag; qualifies the ack pulse it accompanies
- stall_req_o  out  1  pipeline stall request to control

Behaviour:
Reset
- rst is synchronous and active-high.
- All registered outputs go to 0 and the FSM goes to IDLE.
- stall_req_o follows its combinational equation.
- Reset during a bus cycle abandons the cycle. A late bus_ack_i seen in IDLE is ignored.

FSM states: IDLE, MEM_BUSY, IF_BUSY.
- IDLE -> MEM_BUSY when mem_req_i=1 and mem_ack_o=0.
- IDLE -> IF_BUSY when only the IF request is eligible (if_req_i=1 and if_ack_o=0).
- MEM wins when both requests are eligible.
- A requester whose ack is high in the current cycle is ineligible. This prevents a double issue while it drops its request.

Bus cycle
- On the grant edge, bus_req_o=1 and bus_we_o/addr/wdata/sel are registered from the winner.
- IF grants use we=0 and sel=4'b1111.
- All bus outputs stay stable until bus_ack_i is sampled high.

Completion (BUSY state with bus_ack_i=1)
- Next edge: bus_req_o=0, FSM returns to IDLE, and the owner's ack_o=1 for exactly one cycle.
- Owner's rdata_o <= bus_rdata_i for loads and IF; a store leaves mem_rdata_o unchanged.
- rdata_o holds its value until the next completion for that requester.

Latency and throughput
- Minimum latency: request at cycle N, bus_req_o at N+1, slave ack at N+1, ack_o at N+2.
- A new grant can occur at N+2, so back-to-back throughput is one transaction per 2 cycles.

Stall and invalid inputs
- stall_req_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o), purely combinational.
- bus_ack_i while in IDLE is ignored.
- Request input changes during BUSY have no effect on the bus outputs.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - A cycle counter clears on grant and increments each BUSY cycle without bus_ack_i.
  - When the count reaches TIMEOUT_CYCLES, the cycle completes on the next edge exactly as a normal completion, except owner rdata_o <= 0 and err_o=1 for that ack cycle.
  - A bus_ack_i arriving in the same cycle as the timeout takes precedence, so there is no error.
- Undefined:
  - The counter is absent and err_o is tied to 0.
  - BUSY waits for bus_ack_i indefinitely.

Decomposition:
- Shared defines package holds:
  - DataBus, AddrBus, SelBus width macros
  - ZeroData and ZeroDataAddr
  - RstEnable, WriteEnable/WriteDisable
  - FSM state encodings ARB_IDLE, ARB_MEM, ARB_IF
- One natural sub-module: bus_watchdog, holding the counter and the timeout compare. It is instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- MEM load, addr 0x100, slave acks 2 cycles after bus_req_o with rdata 0xDEADBEEF -> mem_ack_o pulses 1 cycle, mem_rdata_o=0xDEADBEEF, stall_req_o high from request until the ack cycle.
- IF and MEM requests asserted in the same cycle, zero-wait slave -> MEM served first (ack at N+2), IF granted at N+2 (ack at N+4), bus_addr_o never changes mid-cycle.
- MEM store, wdata 0x12345678, sel 4'b0011 -> bus_we_o=1, bus_sel_o=0011, mem_rdata_o unchanged, no IF disturbance.
- Requester keeps req high during its ack cycle then drops it -> exactly one bus cycle issued.
- rst pulsed while bus_req_o=1, slave acks the cycle after -> all outputs 0, no ack_o pulse, FSM in IDLE.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> ack_o and err_o pulse together, rdata_o=0, bus_req_o drops, next request is served normally.
